// File: rtl/tone_sequencer_if.sv
// Control/status bundle between a melody requester and tone_sequencer.
// Requester drives START/STOP/LOOP; the sequencer drives the registered status and speaker pin.
interface tone_sequencer_if #(
    parameter int IDX_W = 3
);
    logic             START;
    logic             STOP;
    logic             LOOP;
    logic             BUSY;
    logic             DONE;
    logic [IDX_W-1:0] NOTE_IDX;
    logic             SPEAKER;

    modport master (
        output START, STOP, LOOP,
        input  BUSY, DONE, NOTE_IDX, SPEAKER
    );

    modport slave (
        input  START, STOP, LOOP,
        output BUSY, DONE, NOTE_IDX, SPEAKER
    );
endinterface

// File: rtl/tone_sequencer.sv
// Square-wave melody player stepping a parameter note table; TONE_SEQ_GAP_EN adds silence between notes.
// Latency: BUSY the cycle after START, tone the cycle after that; one LOAD cycle per table entry.
// No backpressure: START is ignored while running, STOP aborts from any state without DONE.
module tone_sequencer #(
    parameter int NOTES      = 8,
    parameter int STEP_TICKS = 1600000,
    parameter logic [20*NOTES-1:0] TABLE = {
        20'h0,
        {16'd16198, 4'd2}, {16'd18182, 4'd2}, {16'd20408, 4'd2}, {16'd22908, 4'd2},
        {16'd24270, 4'd2}, {16'd27242, 4'd2}, {16'd30578, 4'd2}
    },
    parameter int GAP_TICKS  = 160000
) (
    input  logic            CLK,
    input  logic            RST,
    tone_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(NOTES);
    localparam int DUR_W = $clog2(15 * STEP_TICKS);
    localparam logic [DUR_W-1:0] STEP_W = DUR_W'(STEP_TICKS);
`ifdef TONE_SEQ_GAP_EN
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    function automatic logic [3:0] dur_of(input logic [IDX_W-1:0] i);
        return TABLE[20*i +: 4];
    endfunction

    function automatic logic [15:0] div_of(input logic [IDX_W-1:0] i);
        return TABLE[20*i + 4 +: 16];
    endfunction

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      div;
    logic [15:0]      half_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic [DUR_W-1:0] dur_lim;
    logic             speaker;
    logic             busy;
    logic             done;
    logic             wrapped;
`ifdef TONE_SEQ_GAP_EN
    logic [GAP_W-1:0] gap_cnt;
`endif

    logic [IDX_W-1:0] nxt_idx;
    logic [3:0]       cur_dur;
    logic             last;

    assign nxt_idx = idx + IDX_W'(1);
    assign cur_dur = dur_of(idx);
    assign last    = (idx == IDX_W'(NOTES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            idx      <= '0;
            div      <= '0;
            half_cnt <= '0;
            dur_cnt  <= '0;
            dur_lim  <= '0;
            speaker  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrapped  <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && bus.STOP) begin
                state   <= S_IDLE;
                idx     <= '0;
                speaker <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.START && !bus.STOP) begin
                            state   <= S_LOAD;
                            idx     <= '0;
                            busy    <= 1'b1;
                            wrapped <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (cur_dur != 4'd0) begin
                            div      <= div_of(idx);
                            dur_lim  <= DUR_W'(cur_dur) * STEP_W - DUR_W'(1);
                            half_cnt <= '0;
                            dur_cnt  <= '0;
                            speaker  <= 1'b0;
                            state    <= S_PLAY;
                        // a marker at entry 0 seen again after a wrap ends the run
                        end else if (bus.LOOP && !(idx == '0 && wrapped)) begin
                            idx     <= '0;
                            wrapped <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            idx   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (div != 16'd0) begin
                            if (half_cnt == div - 16'd1) begin
                                half_cnt <= '0;
                                speaker  <= ~speaker;
                            end else begin
                                half_cnt <= half_cnt + 16'd1;
                            end
                        end
                        if (dur_cnt == dur_lim) begin
                            speaker <= 1'b0;
                            if (last && !bus.LOOP) begin
                                state <= S_IDLE;
                                idx   <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                if (last) begin
                                    wrapped <= 1'b1;
                                end
`ifdef TONE_SEQ_GAP_EN
                                // silence only when a real note follows; an end marker goes straight on
                                if (dur_of(nxt_idx) != 4'd0) begin
                                    state   <= S_GAP;
                                    gap_cnt <= '0;
                                end else begin
                                    state <= S_LOAD;
                                    idx   <= nxt_idx;
                                end
`else
                                state <= S_LOAD;
                                idx   <= nxt_idx;
`endif
                            end
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end
`ifdef TONE_SEQ_GAP_EN
                    S_GAP: begin
                        if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                            state <= S_LOAD;
                            idx   <= nxt_idx;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
`endif
                    default: begin
                        state   <= S_IDLE;
                        idx     <= '0;
                        speaker <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.BUSY     = busy;
    assign bus.DONE     = done;
    assign bus.NOTE_IDX = idx;
    assign bus.SPEAKER  = speaker;
endmodule
